// File: rtl/imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_port_arbiter
//
// Shares one single-port memory with fixed read latency between the core's
// instruction-fetch port (if_*) and its load/store data port (d_*). Only one
// transaction is outstanding at a time. A new access can be issued on the
// completion cycle of the previous one, so the memory can take one access
// every MEM_LAT cycles.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until it sees *_gnt high in the same cycle. The grant is combinational and
// coincides with the memory strobe (m_req). The response arrives as a
// single-cycle *_rvalid pulse MEM_LAT cycles later. There is no back-pressure
// on responses. A fetch response can be suppressed with if_kill.
//
// Arbitration: the data port wins. After STARVE_MAX data grants in a row
// while a fetch is waiting, the fetch wins once.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_kill             discard the outstanding fetch response
//   if_gnt              fetch accepted this cycle
//   if_rvalid/if_rdata  fetch response pulse and data
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_gnt               data request accepted this cycle
//   d_rvalid/d_rdata    load data or store acknowledge (rdata 0 for stores)
//   m_req/m_we/m_addr/m_wdata  memory access strobe and command
//   m_rdata             memory read data, valid MEM_LAT cycles after m_req
// ---------------------------------------------------------------------------
module imem_dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic       owner_q, owner_d;        // 0 = fetch, 1 = data
    logic       we_q, we_d;              // outstanding data access is a store
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       kill_pend_q, kill_pend_d;

    logic completion;
    logic can_issue;
    logic fetch_wins;
    logic issue_if;
    logic issue_d;

    // Issue decision and arbitration.
    always_comb begin
        completion = (state_q == ST_WAIT) && (lat_cnt_q == LAT_LAST);
        // rst_n gates the combinational grant path so every output is 0
        // while reset is held, even with requests asserted.
        can_issue  = rst_n && ((state_q == ST_IDLE) || completion);
        fetch_wins = if_req && (!d_req || (starve_cnt_q == STARVE_LIM));
        issue_if   = can_issue && fetch_wins;
        issue_d    = can_issue && d_req && !fetch_wins;
    end

    // Request-side outputs.
    always_comb begin
        if_gnt  = issue_if;
        d_gnt   = issue_d;
        m_req   = issue_if || issue_d;
        m_we    = issue_d && d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (issue_d) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (issue_if) begin
            m_addr  = if_addr;
        end
    end

    // Response-side outputs. A kill on the completion cycle itself also
    // suppresses the fetch response.
    always_comb begin
        d_rvalid  = completion && owner_q;
        d_rdata   = (d_rvalid && !we_q) ? m_rdata : '0;
        if_rvalid = completion && !owner_q && !kill_pend_q && !if_kill;
        if_rdata  = if_rvalid ? m_rdata : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        kill_pend_d  = kill_pend_q;
        starve_cnt_d = starve_cnt_q;

        if (issue_if || issue_d) begin
            state_d     = ST_WAIT;
            lat_cnt_d   = '0;
            owner_d     = issue_d;
            we_d        = issue_d && d_we;
            kill_pend_d = 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (completion) begin
                state_d     = ST_IDLE;
                lat_cnt_d   = '0;
                kill_pend_d = 1'b0;
            end else begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (if_kill && !owner_q) begin
                    kill_pend_d = 1'b1;
                end
            end
        end

        // Counts data grants that overtook a waiting fetch.
        if (!if_req || issue_if) begin
            starve_cnt_d = '0;
        end else if (issue_d && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_q    <= '0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            starve_cnt_q <= '0;
            kill_pend_q  <= 1'b0;
        end else begin
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            starve_cnt_q <= starve_cnt_d;
            kill_pend_q  <= kill_pend_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_port_arbiter
//
// Directed bench for imem_dmem_port_arbiter with MEM_LAT=2, STARVE_MAX=4.
// A small memory model returns rd_model(addr) exactly MEM_LAT cycles after a
// read strobe and a junk pattern otherwise. Expected responses are queued at
// grant time and popped on each rvalid pulse.
// ---------------------------------------------------------------------------
module tb_imem_dmem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_kill, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    logic          gnt_hist[$];   // 1 = data grant, 0 = fetch grant

    logic          s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_m_req, s_m_we;
    logic [DW-1:0] s_if_rdata, s_d_rdata, s_m_wdata;
    logic [AW-1:0] s_m_addr;

    imem_dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    logic          pipe_v[MEM_LAT] = '{default: 1'b0};
    logic [AW-1:0] pipe_a[MEM_LAT] = '{default: '0};

    always @(posedge clk) begin
        pipe_v[0] <= m_req && !m_we;
        pipe_a[0] <= m_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    always_comb begin
        m_rdata = JUNK;
        if (pipe_v[MEM_LAT-1]) m_rdata = rd_model(pipe_a[MEM_LAT-1]);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},    32'(if_gnt),    0);
        chk({tag, "_d_gnt"},     32'(d_gnt),     0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, "_d_rvalid"},  32'(d_rvalid),  0);
        chk({tag, "_if_rdata"},  if_rdata,       0);
        chk({tag, "_d_rdata"},   d_rdata,        0);
        chk({tag, "_m_req"},     32'(m_req),     0);
        chk({tag, "_m_we"},      32'(m_we),      0);
        chk({tag, "_m_addr"},    m_addr,         0);
        chk({tag, "_m_wdata"},   m_wdata,        0);
    endtask

    // One clock cycle: sample on the falling edge, run the scoreboard,
    // then return 1 ns after the rising edge so the caller can drive inputs.
    task automatic tick();
        @(negedge clk);
        s_if_gnt    = if_gnt;    s_d_gnt    = d_gnt;
        s_if_rvalid = if_rvalid; s_d_rvalid = d_rvalid;
        s_if_rdata  = if_rdata;  s_d_rdata  = d_rdata;
        s_m_req     = m_req;     s_m_we     = m_we;
        s_m_addr    = m_addr;    s_m_wdata  = m_wdata;

        chk("gnt_onehot", 32'(if_gnt && d_gnt), 0);
        chk("m_req_vs_gnt", 32'(m_req), 32'(if_gnt || d_gnt));
        if (d_gnt) begin
            d_exp_q.push_back(d_we ? '0 : rd_model(d_addr));
            gnt_hist.push_back(1'b1);
            chk("d_m_addr",  m_addr,      d_addr);
            chk("d_m_we",    32'(m_we),   32'(d_we));
            chk("d_m_wdata", m_wdata,     d_wdata);
        end else if (if_gnt) begin
            if_exp_q.push_back(rd_model(if_addr));
            gnt_hist.push_back(1'b0);
            chk("if_m_addr",  m_addr,    if_addr);
            chk("if_m_we",    32'(m_we), 0);
            chk("if_m_wdata", m_wdata,   0);
        end else begin
            chk("idle_m_addr",  m_addr,    0);
            chk("idle_m_wdata", m_wdata,   0);
            chk("idle_m_we",    32'(m_we), 0);
        end

        if (if_rvalid) begin
            if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 0);
            else                      chk("if_rdata", if_rdata, if_exp_q.pop_front());
        end else begin
            chk("if_rdata_idle", if_rdata, 0);
        end
        if (d_rvalid) begin
            if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 0);
            else                     chk("d_rdata", d_rdata, d_exp_q.pop_front());
        end else begin
            chk("d_rdata_idle", d_rdata, 0);
        end

        @(posedge clk);
        #1;
    endtask

    // Drop requests and wait (bounded) until every expected response arrived.
    task automatic drain(input string tag);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_kill = 1'b0;
        for (int c = 0; c < 20 && (if_exp_q.size() + d_exp_q.size()) != 0; c++) tick();
        chk({tag, "_drain"}, 32'(if_exp_q.size() + d_exp_q.size()), 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic exp_order[6];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #2;
        chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;

        // Single fetch.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("t1_if_gnt", 32'(s_if_gnt), 1);
        chk("t1_m_req",  32'(s_m_req),  1);
        chk("t1_m_addr", s_m_addr,      32'h100);
        if_req = 1'b0;
        tick();
        chk("t1_c1_if_rvalid", 32'(s_if_rvalid), 0);
        tick();
        chk("t1_c2_if_rvalid", 32'(s_if_rvalid), 1);
        chk("t1_c2_if_rdata",  s_if_rdata,       32'hDEAD_BEEF);
        tick();
        chk("t1_c3_if_rvalid", 32'(s_if_rvalid), 0);

        // Contention: data first, fetch on the completion cycle.
        if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick();
        chk("t2_c0_d_gnt",  32'(s_d_gnt),  1);
        chk("t2_c0_if_gnt", 32'(s_if_gnt), 0);
        d_req = 1'b0;
        tick();
        chk("t2_c1_if_gnt", 32'(s_if_gnt), 0);
        tick();
        chk("t2_c2_d_rvalid", 32'(s_d_rvalid), 1);
        chk("t2_c2_if_gnt",   32'(s_if_gnt),   1);
        if_req = 1'b0;
        tick();
        chk("t2_c3_if_rvalid", 32'(s_if_rvalid), 0);
        tick();
        chk("t2_c4_if_rvalid", 32'(s_if_rvalid), 1);
        tick();

        // Starvation: both ports request continuously.
        gnt_hist.delete();
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 0; c < 60 && gnt_hist.size() < 6; c++) begin
            tick();
            if (s_d_gnt)  d_addr  = d_addr + 32'd4;
            if (s_if_gnt) if_addr = if_addr + 32'd4;
        end
        chk("t3_grant_count", 32'(gnt_hist.size()), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_order_%0d", i),
                32'((i < gnt_hist.size()) ? gnt_hist[i] : 1'bx), 32'(exp_order[i]));
        end
        drain("t3");

        // Store: write command in the issue cycle, ack with zero data.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        tick();
        chk("t4_d_gnt",   32'(s_d_gnt), 1);
        chk("t4_m_we",    32'(s_m_we),  1);
        chk("t4_m_wdata", s_m_wdata,    32'h1234_5678);
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        tick();
        chk("t4_c1_d_rvalid", 32'(s_d_rvalid), 0);
        tick();
        chk("t4_c2_d_rvalid", 32'(s_d_rvalid), 1);
        chk("t4_c2_d_rdata",  s_d_rdata,       0);
        tick();

        // Kill in the issue cycle is ignored.
        if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h140;
        tick();
        chk("t5_if_gnt", 32'(s_if_gnt), 1);
        if_req = 1'b0; if_kill = 1'b0;
        tick();
        tick();
        chk("t5_if_rvalid", 32'(s_if_rvalid), 1);
        tick();

        // Kill during WAIT suppresses the response; data granted at completion.
        if_req = 1'b1; if_addr = 32'h180;
        tick();
        chk("t6_if_gnt", 32'(s_if_gnt), 1);
        if_req = 1'b0; if_kill = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h280;
        tick();
        chk("t6_c1_d_gnt", 32'(s_d_gnt), 0);
        if (if_exp_q.size() != 0) void'(if_exp_q.pop_front());
        if_kill = 1'b0;
        tick();
        chk("t6_c2_if_rvalid", 32'(s_if_rvalid), 0);
        chk("t6_c2_d_gnt",     32'(s_d_gnt),     1);
        d_req = 1'b0;
        tick();
        tick();
        chk("t6_c4_d_rvalid", 32'(s_d_rvalid), 1);
        tick();

        // Reset in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h1C0;
        tick();
        chk("t7_if_gnt", 32'(s_if_gnt), 1);
        d_req = 1'b1; d_addr = 32'h2C0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t7_rst");
        if_exp_q.delete();
        d_exp_q.delete();
        tick();
        chk_all_zero("t7_rst_c1");
        tick();
        chk_all_zero("t7_rst_c2");
        d_req = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t7_post_if_gnt", 32'(s_if_gnt), 1);
        drain("t7");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Grants one transaction at a time and sequences the fixed memory latency with a counter.
- Returns read data or a write acknowledge to the requester that owns the transaction.
- Data port has priority; a starvation counter guarantees fetch progress. Sits between the pipelined core and the memory macro.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from issue to memory data valid; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  pipeline flush; discards the outstanding fetch response.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, 1-cycle pulse.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid or store ack, 1-cycle pulse.
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after the m_req cycle.

Behaviour:
- Clock and reset: one clock domain. rst_n low asynchronously clears all state: FSM=IDLE, lat_cnt=0, owner=0, starve_cnt=0, kill_pend=0. While rst_n is low, all outputs are 0.
- FSM states: IDLE (no transaction outstanding) and WAIT (transaction outstanding).
- Issue condition: a cycle can issue if FSM=IDLE, or FSM=WAIT and lat_cnt==MEM_LAT-1 (completion cycle). This allows back-to-back issue, one transaction every MEM_LAT cycles.
- Issue cycle:
  - m_req=1; m_addr, m_we, m_wdata come from the winner.
  - m_we=d_we for the data port; m_we=0 and m_wdata=0 for fetch.
  - Exactly one of if_gnt/d_gnt is 1, combinational in the same cycle.
  - Next state WAIT, lat_cnt=0, owner latched (0=fetch, 1=data), kill_pend=0.
  - When no issue happens, m_req/m_we/m_addr/m_wdata are 0.
- Arbitration:
  - d_req wins unless if_req=1 and starve_cnt==STARVE_MAX; in that case fetch wins.
  - With only one request active, that request wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each data grant while if_req=1.
  - Clears on a fetch grant or any cycle with if_req=0.
- WAIT:
  - lat_cnt increments each cycle.
  - On the cycle lat_cnt==MEM_LAT-1, the transaction completes:
    - owner=data: d_rvalid=1, d_rdata=m_rdata (0 for stores).
    - owner=fetch: if_rvalid=1, if_rdata=m_rdata, unless kill_pend=1 or if_kill=1 this cycle, in which case if_rvalid=0.
  - If nothing issues that cycle, next state is IDLE.
- MEM_LAT=1: completion occurs the cycle after issue (a single WAIT cycle).
- if_kill:
  - Sets kill_pend when FSM=WAIT and owner=fetch.
  - Ignored otherwise, including in the issue cycle, where the fetch is still accepted.
  - A killed fetch still occupies the memory for its full latency.
- Outside completion cycles, rvalid outputs are 0 and rdata outputs are 0.
- Reset mid-transaction: the transaction is dropped and no rvalid is produced; after release, the block accepts a new request in the first cycle.
- Simultaneous events: a completion and a new issue in the same cycle are legal; the rvalid belongs to the old owner and the gnt to the new winner.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x100 at cycle 0 → if_gnt=1 and m_req=1 at c0; m_rdata=0xDEADBEEF at c2 → if_rvalid=1 and if_rdata=0xDEADBEEF at c2 only.
- Contention: if_req and d_req both 1 at c0 (load, d_addr=0x200) → d_gnt at c0, if_gnt at c2; d_rvalid at c2, if_rvalid at c4.
- Starvation, STARVE_MAX=4: d_req held high for 6 transactions with if_req held high → grant order D, D, D, D, IF, D.
- Store: d_we=1, d_addr=0x40, d_wdata=0x12345678 → m_we=1, m_wdata=0x12345678 in the issue cycle; d_rvalid pulses after MEM_LAT cycles with d_rdata=0.
- Kill: fetch granted at c0, if_kill=1 at c1 (MEM_LAT=2) → no if_rvalid at c2; a pending d_req is granted at c2.
- Reset mid-WAIT: rst_n=0 at c1 after a fetch grant at c0 → all outputs 0 immediately, no rvalid ever; after release, if_req is granted in the first cycle.
